// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the burst memory controller: FSM states, width defaults,
// and the token that tracks in-flight read beats.
package mem_ctrl_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefLenW  = 3;
    localparam int unsigned DefRdLat = 1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_tok_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Request/response and RAM-side signals of the burst controller.
// The slave modport is the controller; the master modport is the requester plus RAM.
interface mem_burst_ctrl_if
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LEN_W  = DefLenW
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_rd_en;
    logic              ram_wr_en;

    modport master (
        output req_valid, req_rw, req_addr, req_len, req_wdata, ram_dout,
        input  req_ready, rd_data, rd_valid, rd_last, busy,
        input  ram_addr, ram_din, ram_rd_en, ram_wr_en
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_len, req_wdata, ram_dout,
        output req_ready, rd_data, rd_valid, rd_last, busy,
        output ram_addr, ram_din, ram_rd_en, ram_wr_en
    );

endinterface

// File: rtl/mem_burst_ctrl_rd_lat_pipe.sv
// Shift register of read tokens that tracks beats in flight through the RAM.
// Stage 0 lines up with the ram_rd_en cycle; the last stage lines up with valid ram_dout.
module rd_lat_pipe
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DefRdLat
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tok_t push,
    output rd_tok_t out,
    output logic    empty
);

    rd_tok_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= push;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_q[i].valid) empty = 1'b0;
        end
    end

    assign out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: single-beat writes, up to 2^LEN_W-beat reads, RD_LAT cycles from
// ram_rd_en to rd_valid. Define MEMCTL_WRAP_EN for wrapping (critical-word-first) read bursts.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned LEN_W  = DefLenW,
    parameter int unsigned RD_LAT = DefRdLat
) (
    input logic             clk,
    input logic             reset,
    mem_burst_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic              busy_q;
    logic              rd_valid_q, rd_last_q;
    logic [DATA_W-1:0] rd_data_q;
    rd_tok_t           tok, pipe_out;
    logic              pipe_empty;

`ifdef MEMCTL_WRAP_EN
    localparam logic [ADDR_W-1:0] WrapMask = ADDR_W'((1 << LEN_W) - 1);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a & ~WrapMask) | ((a + 1'b1) & WrapMask);
    endfunction
`else
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + 1'b1;
    endfunction
`endif

    // RAM strobes and address are registered, so the beat issued in a cycle is decided here
    // one cycle earlier; the token is pushed at the same edge to stay aligned with it.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_rd_en_d = 1'b0;
        ram_wr_en_d = 1'b0;
        tok         = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    len_d      = bus.req_len;
                    cnt_d      = '0;
                    ram_addr_d = bus.req_addr;
                    if (bus.req_rw) begin
                        state_d     = StWrite;
                        ram_wr_en_d = 1'b1;
                        ram_din_d   = bus.req_wdata;
                    end else begin
                        state_d     = StRead;
                        ram_rd_en_d = 1'b1;
                        tok.valid   = 1'b1;
                        tok.last    = (bus.req_len == '0);
                    end
                end
            end
            StWrite: state_d = StIdle;
            StRead: begin
                if (cnt_q == len_q) begin
                    state_d = StDrain;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    ram_addr_d  = next_addr(ram_addr_q);
                    ram_rd_en_d = 1'b1;
                    tok.valid   = 1'b1;
                    tok.last    = (cnt_d == len_q);
                end
            end
            StDrain: begin
                if (pipe_empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_rd_en_q <= 1'b0;
            ram_wr_en_q <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_wr_en_q <= ram_wr_en_d;
            busy_q      <= (state_d != StIdle);
            rd_valid_q  <= pipe_out.valid;
            rd_last_q   <= pipe_out.valid & pipe_out.last;
            rd_data_q   <= pipe_out.valid ? bus.ram_dout : '0;
        end
    end

    rd_lat_pipe #(
        .DEPTH(RD_LAT)
    ) u_pipe (
        .clk  (clk),
        .reset(reset),
        .push (tok),
        .out  (pipe_out),
        .empty(pipe_empty)
    );

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = busy_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.ram_rd_en = ram_rd_en_q;
    assign bus.ram_wr_en = ram_wr_en_q;

endmodule
